// File: rtl/thumb_overlay.sv
// Double-buffered 32x32 grayscale thumbnail store with a 2-stage display read pipeline.
// The resizer fills the back bank; banks swap only in vertical blanking so the overlay never tears.
module thumb_overlay #(
  parameter logic [9:0] X0         = 10'd0,
  parameter logic [9:0] Y0         = 10'd0,
  parameter int         SCALE_LOG2 = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iStart,
  input  logic       iWr,
  input  logic [7:0] iPix,
  input  logic       iVblank,
  input  logic       iReq,
  input  logic [9:0] iX,
  input  logic [9:0] iY,
  output logic [7:0] oPix,
  output logic       oInWin,
  output logic       oValid,
  output logic       oHaveFrame,
  output logic [7:0] oFrameCnt,
  output logic       oOverflow
);

  typedef enum logic {FILL, PEND} state_t;

  localparam logic [10:0] WIN = 11'(32 << SCALE_LOG2);
  localparam logic [10:0] XL  = {1'b0, X0};
  localparam logic [10:0] YT  = {1'b0, Y0};

  logic [7:0] bank0 [1024];
  logic [7:0] bank1 [1024];

  state_t     state;
  logic [9:0] waddr;
  logic       fbank;
  logic       we;

  // ---------------- write side ----------------
  assign we = (state == FILL) && iWr && !iStart;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      waddr      <= '0;
      fbank      <= 1'b0;
      oHaveFrame <= 1'b0;
      oFrameCnt  <= '0;
      oOverflow  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (iStart) begin
            waddr     <= '0;
            oOverflow <= 1'b0;
          end else if (iWr) begin
            waddr <= waddr + 10'd1;
            if (waddr == 10'd1023) state <= PEND;
          end
        end
        PEND: begin
          // a start pulse only clears the sticky flag; the finished frame still swaps
          if (iStart)   oOverflow <= 1'b0;
          else if (iWr) oOverflow <= 1'b1;
          if (iVblank) begin
            fbank      <= ~fbank;
            oFrameCnt  <= oFrameCnt + 8'd1;
            oHaveFrame <= 1'b1;
            state      <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // back bank is the one not selected by fbank
  always_ff @(posedge clk) begin
    if (we) begin
      if (fbank) bank0[waddr] <= iPix;
      else       bank1[waddr] <= iPix;
    end
  end

  // ---------------- read side ----------------
  logic [10:0] xe, ye, dx, dy;
  logic        in_win;
  logic [4:0]  row, col;

  assign xe     = {1'b0, iX};
  assign ye     = {1'b0, iY};
  assign dx     = xe - XL;
  assign dy     = ye - YT;
  assign in_win = (xe >= XL) && (xe < XL + WIN) && (ye >= YT) && (ye < YT + WIN);
  assign row    = 5'(dy >> SCALE_LOG2);
  assign col    = 5'(dx >> SCALE_LOG2);

  logic [1:0] vld_pipe;
  logic       s1_win, s1_bank, s1_have;
  logic [9:0] s1_addr;
  logic       pix_en;
  logic [7:0] rd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_win   <= 1'b0;
      s1_bank  <= 1'b0;
      s1_have  <= 1'b0;
      s1_addr  <= '0;
      oInWin   <= 1'b0;
      pix_en   <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[0], iReq};
      s1_win   <= in_win;
      s1_bank  <= fbank;
      s1_have  <= oHaveFrame;
      s1_addr  <= {row, col};
      oInWin   <= s1_win;
      pix_en   <= s1_win && s1_have;
    end
  end

  // RAM read uses the bank captured in stage 1, so a swap cannot disturb a request in flight
  always_ff @(posedge clk) begin
    rd_q <= s1_bank ? bank1[s1_addr] : bank0[s1_addr];
  end

  assign oValid = vld_pipe[1];
  assign oPix   = pix_en ? rd_q : 8'h00;

endmodule

// File: tb/tb_thumb_overlay.sv
// Directed bench for thumb_overlay: fill, swap, window edges, overflow, restart and a streaming swap.
module tb_thumb_overlay;

  localparam logic [9:0] X0 = 10'd100;
  localparam logic [9:0] Y0 = 10'd40;
  localparam int         SC = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       iStart, iWr, iVblank, iReq;
  logic [7:0] iPix;
  logic [9:0] iX, iY;
  logic [7:0] oPix, oFrameCnt;
  logic       oInWin, oValid, oHaveFrame, oOverflow;

  int total = 0;
  int bad   = 0;

  thumb_overlay #(.X0(X0), .Y0(Y0), .SCALE_LOG2(SC)) dut (
    .clk(clk), .rst_n(rst_n), .iStart(iStart), .iWr(iWr), .iPix(iPix),
    .iVblank(iVblank), .iReq(iReq), .iX(iX), .iY(iY), .oPix(oPix),
    .oInWin(oInWin), .oValid(oValid), .oHaveFrame(oHaveFrame),
    .oFrameCnt(oFrameCnt), .oOverflow(oOverflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    total++;
    if (obs !== expd) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, expd);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_n(input int n, input logic [7:0] v, input bit patt);
    for (int i = 0; i < n; i++) begin
      iWr  = 1'b1;
      iPix = patt ? i[7:0] : v;
      step();
    end
    iWr = 1'b0;
  endtask

  task automatic vblank_pulse();
    iVblank = 1'b1;
    step();
    iVblank = 1'b0;
  endtask

  task automatic rd(input string tag, input int x, input int y, input logic [7:0] pix, input logic win);
    iReq = 1'b1;
    iX   = 10'(x);
    iY   = 10'(y);
    step();
    iReq = 1'b0;
    step();
    chk({tag, ".vld"}, {31'd0, oValid}, 32'd1);
    chk({tag, ".win"}, {31'd0, oInWin}, {31'd0, win});
    chk({tag, ".pix"}, {24'd0, oPix}, {24'd0, pix});
  endtask

  initial begin
    rst_n = 1'b0; iStart = 1'b0; iWr = 1'b0; iPix = '0; iVblank = 1'b0;
    iReq = 1'b0; iX = '0; iY = '0;
    repeat (3) step();
    chk("rst.vld", {31'd0, oValid}, 32'd0);
    chk("rst.pix", {24'd0, oPix}, 32'd0);
    chk("rst.have", {31'd0, oHaveFrame}, 32'd0);
    chk("rst.cnt", {24'd0, oFrameCnt}, 32'd0);
    chk("rst.ovf", {31'd0, oOverflow}, 32'd0);
    rst_n = 1'b1;
    step();

    // no frame yet: inside window but black
    rd("noframe", X0, Y0, 8'h00, 1'b1);

    // frame 1: pixel value = raster index & 0xFF; no swap without vblank
    wr_n(1024, 8'h00, 1'b1);
    repeat (2) step();
    chk("f1.cnt_pre", {24'd0, oFrameCnt}, 32'd0);
    chk("f1.have_pre", {31'd0, oHaveFrame}, 32'd0);
    vblank_pulse();
    chk("f1.cnt", {24'd0, oFrameCnt}, 32'd1);
    chk("f1.have", {31'd0, oHaveFrame}, 32'd1);
    rd("f1.r2c5", X0 + 47, Y0 + 16, 8'd69, 1'b1);
    rd("f1.corner", X0 + 255, Y0 + 255, 8'hFF, 1'b1);
    rd("f1.origin", X0, Y0, 8'h00, 1'b1);
    rd("f1.right", X0 + 256, Y0, 8'h00, 1'b0);
    rd("f1.left", X0 - 1, Y0, 8'h00, 1'b0);
    rd("f1.below", X0, Y0 + 256, 8'h00, 1'b0);
    rd("f1.above", X0 + 10, Y0 - 1, 8'h00, 1'b0);

    // frame 2 pending, extra pixels dropped
    wr_n(1024, 8'h55, 1'b0);
    chk("f2.ovf_pre", {31'd0, oOverflow}, 32'd0);
    wr_n(10, 8'h11, 1'b0);
    chk("f2.ovf", {31'd0, oOverflow}, 32'd1);
    rd("f2.front_kept", X0 + 47, Y0 + 16, 8'd69, 1'b1);
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    chk("f2.ovf_clr", {31'd0, oOverflow}, 32'd0);
    chk("f2.cnt_pre", {24'd0, oFrameCnt}, 32'd1);
    vblank_pulse();
    chk("f2.cnt", {24'd0, oFrameCnt}, 32'd2);
    rd("f2.a0", X0, Y0, 8'h55, 1'b1);
    rd("f2.a9", X0 + 72, Y0, 8'h55, 1'b1);
    rd("f2.a1023", X0 + 255, Y0 + 255, 8'h55, 1'b1);

    // frame 3: partial fill aborted by a start pulse that also carries a discarded pixel
    wr_n(500, 8'h33, 1'b0);
    iStart = 1'b1; iWr = 1'b1; iPix = 8'h77;
    step();
    iStart = 1'b0; iWr = 1'b0;
    wr_n(1024, 8'hAA, 1'b0);
    chk("f3.ovf", {31'd0, oOverflow}, 32'd0);
    vblank_pulse();
    chk("f3.cnt", {24'd0, oFrameCnt}, 32'd3);
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++)
        rd($sformatf("f3.r%0dc%0d", r, c), X0 + c * 8 + (r % 8), Y0 + r * 8 + (c % 8), 8'hAA, 1'b1);

    // frame 4 pending; stream one request per cycle across the swap
    wr_n(1024, 8'hC3, 1'b0);
    for (int i = 0; i <= 10; i++) begin
      iReq    = (i < 10);
      iX      = 10'(X0 + i * 8);
      iY      = Y0;
      iVblank = (i == 4);
      step();
      if (i >= 1) begin
        chk($sformatf("st.vld%0d", i - 1), {31'd0, oValid}, 32'd1);
        chk($sformatf("st.pix%0d", i - 1), {24'd0, oPix}, (i - 1 <= 4) ? 32'h0AA : 32'h0C3);
      end
    end
    iReq = 1'b0; iVblank = 1'b0;
    step();
    chk("st.idle", {31'd0, oValid}, 32'd0);
    chk("st.cnt", {24'd0, oFrameCnt}, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
